// File: rtl/majority_vote_filter_if.sv
// Sample/result bundle for majority_vote_filter.
// The master drives samples and clear; the slave (the filter) returns the
// spatial vote stream and the debounced vote stream.
interface majority_vote_filter_if #(
  parameter int N_IN = 5,
  parameter int WIN  = 4
);
  localparam int CW = $clog2(N_IN + 1);
  localparam int HW = $clog2(WIN + 1);

  logic            in_valid;
  logic [N_IN-1:0] in_vec;
  logic [1:0]      mode;
  logic            clear;
  logic            raw_valid;
  logic            vote_raw;
  logic [CW-1:0]   popcount;
  logic            filt_valid;
  logic            vote_filt;
  logic [HW-1:0]   hist_cnt;

  modport master (
    output in_valid, in_vec, mode, clear,
    input  raw_valid, vote_raw, popcount, filt_valid, vote_filt, hist_cnt
  );

  modport slave (
    input  in_valid, in_vec, mode, clear,
    output raw_valid, vote_raw, popcount, filt_valid, vote_filt, hist_cnt
  );
endinterface

// File: rtl/majority_vote_filter.sv
// Two-stage majority voter.
// Stage 1 registers the spatial vote (rule-selected, with priority override)
// and the popcount of each accepted sample. Stage 2 pushes that vote into a
// WIN-deep history and runs a LOW/HIGH hysteresis filter on the number of
// ones in the window. clear flushes everything except the last raw result.
module majority_vote_filter #(
  parameter int              N_IN      = 5,
  parameter int              THRESH    = 3,
  parameter logic [N_IN-1:0] PRIO_MASK = N_IN'(5'b01000),
  parameter int              WIN       = 4,
  parameter int              K_TEMP    = 3
) (
  input logic                   clk,
  input logic                   reset,
  majority_vote_filter_if.slave bus
);

  localparam int CW = $clog2(N_IN + 1);
  localparam int HW = $clog2(WIN + 1);

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } filt_state_t;

  logic [CW-1:0] w_popcount;
  logic          w_prio;
  logic          w_ruleVote;
  logic          w_vote;

  logic          r_rawValid;
  logic          r_voteRaw;
  logic [CW-1:0] r_popcount;

  logic [WIN-1:0] w_histNext;
  logic [HW-1:0]  w_histCntNext;

  logic [WIN-1:0] r_hist;
  logic [HW-1:0]  r_histCnt;
  filt_state_t    r_state;
  logic           r_filtValid;
  logic           r_voteFilt;

  // Count the ones in the incoming voter vector.
  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_popcount = w_popcount + CW'(bus.in_vec[i]);
    end
  end

  // Apply the selected vote rule, then let any priority input force a 1.
  always_comb begin
    w_prio = |(bus.in_vec & PRIO_MASK);
    case (bus.mode)
      2'b00:   w_ruleVote = (w_popcount >= CW'(THRESH));
      2'b01:   w_ruleVote = (w_popcount == CW'(N_IN));
      2'b10:   w_ruleVote = (w_popcount != '0);
      default: w_ruleVote = 1'b0;
    endcase
    w_vote = w_ruleVote | w_prio;
  end

  // Stage 1: capture vote and popcount of each accepted sample; a sample
  // arriving together with clear is dropped, and results hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rawValid <= 1'b0;
      r_voteRaw  <= 1'b0;
      r_popcount <= '0;
    end else if (bus.clear) begin
      r_rawValid <= 1'b0;
    end else if (bus.in_valid) begin
      r_rawValid <= 1'b1;
      r_voteRaw  <= w_vote;
      r_popcount <= w_popcount;
    end else begin
      r_rawValid <= 1'b0;
    end
  end

  // Next history word and running count: add the new vote, drop the evicted
  // oldest bit. The evicted bit was counted on entry, so this never wraps.
  always_comb begin
    w_histNext    = r_hist << 1;
    w_histNext[0] = r_voteRaw;
    w_histCntNext = r_histCnt + HW'(r_voteRaw) - HW'(r_hist[WIN-1]);
  end

  // Stage 2: advance the history on each stage-1 result and run the
  // hysteresis FSM on the updated count so vote_filt lines up with filt_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist      <= '0;
      r_histCnt   <= '0;
      r_state     <= LOW;
      r_filtValid <= 1'b0;
      r_voteFilt  <= 1'b0;
    end else if (bus.clear) begin
      r_hist      <= '0;
      r_histCnt   <= '0;
      r_state     <= LOW;
      r_filtValid <= 1'b0;
      r_voteFilt  <= 1'b0;
    end else if (r_rawValid) begin
      r_hist      <= w_histNext;
      r_histCnt   <= w_histCntNext;
      r_filtValid <= 1'b1;
      case (r_state)
        LOW: begin
          if (w_histCntNext >= HW'(K_TEMP)) begin
            r_state    <= HIGH;
            r_voteFilt <= 1'b1;
          end
        end
        HIGH: begin
          if (w_histCntNext <= HW'(WIN - K_TEMP)) begin
            r_state    <= LOW;
            r_voteFilt <= 1'b0;
          end
        end
        default: begin
          r_state    <= LOW;
          r_voteFilt <= 1'b0;
        end
      endcase
    end else begin
      r_filtValid <= 1'b0;
    end
  end

  assign bus.raw_valid  = r_rawValid;
  assign bus.vote_raw   = r_voteRaw;
  assign bus.popcount   = r_popcount;
  assign bus.filt_valid = r_filtValid;
  assign bus.vote_filt  = r_voteFilt;
  assign bus.hist_cnt   = r_histCnt;

endmodule
